data_mem_bridge: RTL and testbench
==================================

// Module: data_mem_bridge
// PURPOSE
//  Sits directly downstream of the core's data-memory port (o_data_mem_*) and adapts the core's single-cycle
//  load/store request to a valid/ready system bus with a separate read-response channel. Generates lane
//  strobes, aligns read data, detects misalignment, bounds bus latency with a timeout, and holds the
//  pipeline via o_stall until each access completes.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waited in REQ or WAIT_R before abort; 0 disables timeout
//  ERR_RDATA       32'hDEAD_BEEF  read data returned on timeout
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous, active-high reset
//  i_addr            in   32  byte address from core
//  i_write_data      in   32  store data, LSB-justified
//  i_read_en         in   1   load request
//  i_write_en        in   1   store request (read_en && write_en: write wins)
//  i_data_mask       in   2   00 byte, 01 half, 10 word, 11 treated as word
//  o_read_data       out  32  load result, lane-shifted to LSB, zero-extended
//  o_stall           out  1   hold core pipeline
//  o_misaligned      out  1   1-cycle pulse: misaligned access dropped
//  o_bus_err         out  1   1-cycle pulse: access timed out
//  o_bus_valid       out  1   bus request valid
//  i_bus_ready       in   1   bus accepts request
//  o_bus_addr        out  32  {i_addr[31:2],2'b00}, held stable while valid
//  o_bus_we          out  1   1 = write
//  o_bus_wstrb       out  4   byte-lane strobes (writes only; 0 for reads)
//  o_bus_wdata       out  32  store data replicated/shifted into lanes
//  i_bus_rvalid      in   1   read response valid
//  i_bus_rdata       in   32  read response word
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT_R, DONE. Reset -> IDLE; all outputs 0; counter, captured request cleared.
//  - IDLE: req = read_en|write_en. o_stall = req (combinational, same cycle). On req, capture addr, data,
//    mask, we into registers. Aligned -> REQ. Misaligned (half & addr[0]; word & addr[1:0]!=0) -> DONE,
//    o_misaligned=1 in DONE cycle, no bus activity, o_read_data=0, store dropped.
//  - REQ: o_bus_valid=1, fields from captured regs, stable until handshake. valid&ready: write -> DONE;
//    read -> WAIT_R. o_stall=1.
//  - WAIT_R: o_stall=1; i_bus_rvalid ignored in any other state (earliest accepted: cycle after handshake).
//    On rvalid, capture aligned data -> DONE.
//  - DONE: o_stall=0 for exactly one cycle, o_read_data valid this cycle only; core request present this
//    cycle is the same instruction and is NOT re-issued. Next state always IDLE. o_read_data=0 outside DONE.
//  - Lanes: byte strobe = 1<<addr[1:0], wdata = {4{d[7:0]}}; half strobe = addr[1]?1100:0011,
//    wdata = {2{d[15:0]}}; word strobe 1111. Read: byte = rdata>>(8*addr[1:0]) & FF;
//    half = rdata>>(16*addr[1]) & FFFF.
//  - Timeout: 8+ bit counter cleared on entering REQ/WAIT_R, increments each cycle there; on reaching
//    TIMEOUT_CYCLES -> DONE with o_bus_err=1, read data = ERR_RDATA; o_bus_valid drops.
//  - Back-to-back: a new request is sampled earliest in the IDLE cycle after DONE (min 3-cycle access:
//    IDLE, REQ w/ ready, DONE for stores).
//  - rst mid-transfer: immediate return to IDLE, bus_valid low next cycle; outstanding response discarded.
// TESTING
//  1. SW 0x1234_5678 @0x100, ready same cycle -> valid 1 cycle, wstrb=1111, stall 2 cycles, DONE stall=0.
//  2. SB 0xAB @0x103 -> wstrb=1000, wdata=0xABAB_ABAB, addr=0x100.
//  3. LH @0x102, rdata=0xBEEF_1234 after 3-cycle rvalid delay -> o_read_data=0x0000_BEEF in DONE only.
//  4. LW @0x101 -> o_misaligned pulse, no o_bus_valid, o_read_data=0, stall exactly 1 cycle.
//  5. TIMEOUT_CYCLES=4, ready held 0 -> o_bus_err pulse after 4 REQ cycles, read data 0xDEAD_BEEF.
//  6. rst asserted in WAIT_R; late rvalid -> ignored, state IDLE, all outputs 0.

Source files
------------

// File: rtl/data_mem_bridge.sv
// Purpose: adapts the core's single-cycle data-memory load/store to a valid/ready bus with a read-response channel.
// Latency: min 3 cycles per store (IDLE, REQ, DONE); loads add at least one WAIT_R cycle; bounded by TIMEOUT_CYCLES.
// Backpressure: holds o_bus_valid and its fields stable until i_bus_ready; o_stall holds the core until DONE.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_addr, i_write_data             core byte address and LSB-justified store data
//   i_read_en, i_write_en            core load/store request (write wins if both)
//   i_data_mask                      00 byte, 01 half, 10/11 word
//   o_read_data                      aligned, zero-extended load result (valid in DONE only)
//   o_stall                          hold the core pipeline
//   o_misaligned, o_bus_err          one-cycle pulses in DONE: dropped access / timed-out access
//   o_bus_valid, i_bus_ready         request handshake
//   o_bus_addr, o_bus_we             word address and direction
//   o_bus_wstrb, o_bus_wdata         byte-lane strobes and lane-replicated store data
//   i_bus_rvalid, i_bus_rdata        read response
module data_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [1:0]  i_data_mask,
  output logic [31:0] o_read_data,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_wstrb,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_lane;
  logic [1:0]         r_mask;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bus_valid;
  logic               r_bus_we;
  logic [31:0]        r_bus_addr;
  logic [3:0]         r_bus_wstrb;
  logic [31:0]        r_bus_wdata;
  logic [31:0]        r_read_data;
  logic               r_misaligned;
  logic               r_bus_err;

  logic               w_req;
  logic               w_misaligned;
  logic [3:0]         w_wstrb;
  logic [31:0]        w_wdata;
  logic [31:0]        w_byte_shift;
  logic [31:0]        w_half_shift;
  logic [31:0]        w_rdata_aligned;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;

  assign w_req = i_read_en | i_write_en;

  // Mask 11 is handled as a word everywhere, so only bit 1 decides "word".
  assign w_misaligned = ((i_data_mask == 2'b01) && i_addr[0]) ||
                        (i_data_mask[1] && (i_addr[1:0] != 2'b00));

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = i_write_data;
    case (i_data_mask)
      2'b00: begin
        w_wstrb = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte_shift = i_bus_rdata >> {r_lane, 3'b000};
  assign w_half_shift = i_bus_rdata >> {r_lane[1], 4'b0000};

  always_comb begin
    w_rdata_aligned = i_bus_rdata;
    case (r_mask)
      2'b00:   w_rdata_aligned = {24'h0, w_byte_shift[7:0]};
      2'b01:   w_rdata_aligned = {16'h0, w_half_shift[15:0]};
      default: ;
    endcase
  end

  // The counter holds the number of completed cycles in the current phase; the
  // phase aborts in the cycle that would bring it to TIMEOUT_CYCLES.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lane       <= 2'b00;
      r_mask       <= 2'b00;
      r_cnt        <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'h0;
      r_bus_wstrb  <= 4'h0;
      r_bus_wdata  <= 32'h0;
      r_read_data  <= 32'h0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      // Pulses and read data live for the DONE cycle only.
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_read_data  <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_lane      <= i_addr[1:0];
            r_mask      <= i_data_mask;
            r_bus_we    <= i_write_en;
            r_bus_addr  <= {i_addr[31:2], 2'b00};
            r_bus_wstrb <= i_write_en ? w_wstrb : 4'h0;
            r_bus_wdata <= i_write_en ? w_wdata : 32'h0;
            r_cnt       <= '0;
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_bus_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A handshake in the last allowed cycle still wins over the timeout.
          if (i_bus_ready) begin
            r_bus_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= r_bus_we ? S_DONE : S_WAIT_R;
          end else if (w_timeout) begin
            r_bus_valid <= 1'b0;
            r_bus_err   <= 1'b1;
            r_read_data <= ERR_RDATA;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_R: begin
          if (i_bus_rvalid) begin
            r_read_data <= w_rdata_aligned;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_bus_err   <= 1'b1;
            r_read_data <= ERR_RDATA;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In IDLE the stall must rise in the same cycle the core presents a request.
  assign o_stall      = (r_state == S_IDLE) ? w_req : (r_state != S_DONE);
  assign o_read_data  = r_read_data;
  assign o_misaligned = r_misaligned;
  assign o_bus_err    = r_bus_err;
  assign o_bus_valid  = r_bus_valid;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_we     = r_bus_we;
  assign o_bus_wstrb  = r_bus_wstrb;
  assign o_bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed and randomized checks of data_mem_bridge against a transaction-level model.
module tb_data_mem_bridge;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, i_write_data, i_bus_rdata;
  logic        i_read_en, i_write_en, i_bus_ready, i_bus_rvalid;
  logic [1:0]  i_data_mask;
  logic [31:0] o_read_data, o_bus_addr, o_bus_wdata;
  logic        o_stall, o_misaligned, o_bus_err, o_bus_valid, o_bus_we;
  logic [3:0]  o_bus_wstrb;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_addr       (i_addr),
    .i_write_data (i_write_data),
    .i_read_en    (i_read_en),
    .i_write_en   (i_write_en),
    .i_data_mask  (i_data_mask),
    .o_read_data  (o_read_data),
    .o_stall      (o_stall),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .o_bus_valid  (o_bus_valid),
    .i_bus_ready  (i_bus_ready),
    .o_bus_addr   (o_bus_addr),
    .o_bus_we     (o_bus_we),
    .o_bus_wstrb  (o_bus_wstrb),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic stall, input logic valid,
                         input logic mis, input logic err, input logic [31:0] rd);
    chk($sformatf("%s.stall", tag), 32'(o_stall), 32'(stall));
    chk($sformatf("%s.valid", tag), 32'(o_bus_valid), 32'(valid));
    chk($sformatf("%s.misaligned", tag), 32'(o_misaligned), 32'(mis));
    chk($sformatf("%s.bus_err", tag), 32'(o_bus_err), 32'(err));
    chk($sformatf("%s.read_data", tag), o_read_data, rd);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    i_read_en = 1'b0; i_write_en = 1'b0;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'($urandom_range(0, 1)); i_bus_rdata = $urandom;
    #1;
    chk_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // One complete core access. rdy_dly: REQ cycles before ready (>= T means never);
  // rv_dly: WAIT_R cycles before rvalid (>= T means never).
  task automatic do_access(input string tag, input logic we, input logic both,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] mask,
                           input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    logic        mis;
    logic [1:0]  lane;
    logic [3:0]  strb;
    logic [31:0] bwd, exp_rd;
    logic        err;
    lane = addr[1:0];
    mis  = ((mask == 2'b01) && lane[0]) || (mask[1] && (lane != 2'b00));
    case (mask)
      2'b00:   begin strb = 4'(1 << lane);                  bwd = {4{wd[7:0]}};  end
      2'b01:   begin strb = lane[1] ? 4'b1100 : 4'b0011;    bwd = {2{wd[15:0]}}; end
      default: begin strb = 4'b1111;                        bwd = wd;            end
    endcase
    err    = 1'b0;
    exp_rd = 32'h0;

    // IDLE: request presented, stall rises combinationally.
    @(negedge clk);
    i_read_en = !we || both; i_write_en = we;
    i_addr = addr; i_write_data = wd; i_data_mask = mask;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'($urandom_range(0, 1)); i_bus_rdata = $urandom;
    #1;
    chk_out($sformatf("%s/idle", tag), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    if (mis) begin
      @(negedge clk);
      i_bus_rvalid = 1'b0;
      #1;
      chk_out($sformatf("%s/mis_done", tag), 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      return;
    end

    for (int j = 0; j < T; j++) begin
      @(negedge clk);
      i_bus_ready = (j == rdy_dly);
      i_bus_rvalid = 1'($urandom_range(0, 1)); i_bus_rdata = $urandom;
      #1;
      chk_out($sformatf("%s/req%0d", tag, j), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("%s/req%0d.addr", tag, j), o_bus_addr, {addr[31:2], 2'b00});
      chk($sformatf("%s/req%0d.we", tag, j), 32'(o_bus_we), 32'(we));
      chk($sformatf("%s/req%0d.wstrb", tag, j), 32'(o_bus_wstrb), we ? 32'(strb) : 32'h0);
      if (we) chk($sformatf("%s/req%0d.wdata", tag, j), o_bus_wdata, bwd);
      if (j == rdy_dly) break;
    end

    if (rdy_dly >= T) begin
      err = 1'b1; exp_rd = ERR;
    end else if (!we) begin
      for (int i = 0; i < T; i++) begin
        @(negedge clk);
        i_bus_ready = 1'b0;
        i_bus_rvalid = (i == rv_dly);
        i_bus_rdata = (i == rv_dly) ? rdata : $urandom;
        #1;
        chk_out($sformatf("%s/wait%0d", tag, i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        if (i == rv_dly) break;
      end
      if (rv_dly >= T) begin
        err = 1'b1; exp_rd = ERR;
      end else begin
        case (mask)
          2'b00:   exp_rd = (rdata >> (8 * lane)) & 32'h0000_00FF;
          2'b01:   exp_rd = (rdata >> (16 * lane[1])) & 32'h0000_FFFF;
          default: exp_rd = rdata;
        endcase
      end
    end

    // DONE: the core still presents the same request; it must not be re-issued.
    @(negedge clk);
    i_bus_ready = 1'b0; i_bus_rvalid = 1'($urandom_range(0, 1)); i_bus_rdata = $urandom;
    #1;
    chk_out($sformatf("%s/done", tag), 1'b0, 1'b0, 1'b0, err, exp_rd);
  endtask

  initial begin
    logic        we, both;
    logic [1:0]  mask;
    logic [31:0] addr, wd, rd;
    int          rdy, rv, gap;

    rst = 1'b1;
    i_addr = 32'h0; i_write_data = 32'h0; i_read_en = 1'b0; i_write_en = 1'b0;
    i_data_mask = 2'b00; i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.addr", o_bus_addr, 32'h0);
    chk("reset.we", 32'(o_bus_we), 32'h0);
    chk("reset.wstrb", 32'(o_bus_wstrb), 32'h0);
    chk("reset.wdata", o_bus_wdata, 32'h0);
    rst = 1'b0;
    idle_cycle("post_reset");

    do_access("t1_sw",      1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 2'b10, 0,  0, 32'h0);
    do_access("t2_sb",      1'b1, 1'b1, 32'h0000_0103, 32'hFFFF_FFAB, 2'b00, 1,  0, 32'h0);
    idle_cycle("gap1");
    do_access("t3_lh",      1'b0, 1'b0, 32'h0000_0102, 32'h0,         2'b01, 0,  3, 32'hBEEF_1234);
    do_access("t4_lw_mis",  1'b0, 1'b0, 32'h0000_0101, 32'h0,         2'b10, 0,  0, 32'h0);
    idle_cycle("gap2");
    do_access("t5_timeout", 1'b0, 1'b0, 32'h0000_0200, 32'h0,         2'b10, 99, 0, 32'h0);
    do_access("t5_rtimeout",1'b0, 1'b0, 32'h0000_0204, 32'h0,         2'b11, 2,  99, 32'h0);
    do_access("sh_hi",      1'b1, 1'b0, 32'h0000_0402, 32'h0000_C0DE, 2'b01, 3,  0, 32'h0);
    do_access("lb_lane1",   1'b0, 1'b0, 32'h0000_0501, 32'h0,         2'b00, 0,  0, 32'h8899_AABB);

    // Reset in REQ: valid must drop the next cycle.
    @(negedge clk);
    i_read_en = 1'b1; i_write_en = 1'b0; i_addr = 32'h0000_0300; i_data_mask = 2'b10;
    i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req.valid_before", 32'(o_bus_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_read_en = 1'b0;
    #1;
    chk_out("rst_req.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in WAIT_R; a late response must be discarded.
    @(negedge clk);
    i_read_en = 1'b1; i_addr = 32'h0000_0300; i_data_mask = 2'b10;
    @(negedge clk);
    i_bus_ready = 1'b1;
    @(negedge clk);
    i_bus_ready = 1'b0;
    #1;
    chk("rst_wait.stall_before", 32'(o_stall), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_read_en = 1'b0;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hCAFE_F00D;
    #1;
    chk_out("rst_wait.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_wait.addr", o_bus_addr, 32'h0);
    @(negedge clk);
    i_bus_rvalid = 1'b0;
    #1;
    chk_out("rst_wait.late_rvalid", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 150; k++) begin
      we   = 1'($urandom_range(0, 1));
      both = 1'($urandom_range(0, 1));
      mask = 2'($urandom_range(0, 3));
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      rdy  = $urandom_range(0, T + 1);
      rv   = $urandom_range(0, T + 1);
      do_access($sformatf("rnd%0d", k), we, both, addr, wd, mask, rdy, rv, rd);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle($sformatf("rnd%0d_gap", k));
    end

    idle_cycle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
